serial_adder: RTL
=================

# serial_adder

Bit-serial, multi-cycle adder: latches two BITS-wide unsigned operands on a start strobe, adds them one bit per clock through a single full adder and carry flip-flop, and presents `{o_carry, o_sum}` with a one-cycle done pulse. It is the additive counterpart to the combinational Subtractor and serves as the area-minimal adder in the arithmetic library. It also provides a handshake-driven building block for later sequential datapaths such as a shift-add multiplier.

## Interface

- BITS, 4, operand and sum width; legal range 1 to 32.
- i_clock  input  1  rising-edge clock; all state changes on this edge.
- i_reset  input  1  synchronous, active-high reset.
- i_start  input  1  request strobe; sampled on i_clock.
- i_augend  input  BITS  first operand, unsigned; sampled only when a start is accepted.
- i_addend  input  BITS  second operand, unsigned; sampled only when a start is accepted.
- o_busy  output  1  high while an addition is in progress (ADD state).
- o_done  output  1  single-cycle pulse; result valid.
- o_sum  output  BITS  low BITS of augend + addend; registered.
- o_carry  output  1  carry out of the MSB; registered.

## Operation

- States: IDLE, ADD, DONE.
- IDLE:
  - On i_start=1, latch i_augend and i_addend into shift registers A and B, clear carry C, clear bit counter N, and go to ADD.
  - Otherwise stay in IDLE.
- ADD, once per cycle:
  - s = A[0] ^ B[0] ^ C.
  - C <= (A[0]&B[0]) | (A[0]&C) | (B[0]&C).
  - A and B shift right by one.
  - s shifts into the MSB of partial register P, with P shifting right.
  - N increments.
  - When N reaches BITS-1 on this edge, go to DONE and load o_sum <= final P and o_carry <= final C.
- DONE:
  - o_done=1 for exactly this cycle.
  - i_start=1 here is accepted exactly as in IDLE: operands are latched and the next state is ADD, giving back-to-back operation.
  - Otherwise go to IDLE.
- i_start is ignored while in ADD. There is no queueing, and the in-flight operands are unaffected.
- Arithmetic: `{o_carry, o_sum}` == i_augend + i_addend, exact over BITS+1 bits. There is no overflow beyond o_carry.
- o_sum and o_carry change only on entry to DONE and otherwise hold the last result. Partial sums are never visible on the outputs.
- Operand inputs may change freely after the accepting edge.
- Counter N is sized to hold BITS-1, which is at least 1 bit. For BITS=1, ADD lasts one cycle.

## Timing

- Reset, when i_reset=1 at an edge:
  - State becomes IDLE.
  - o_busy, o_done, o_sum, o_carry, A, B, P, C, N all become 0.
  - Reset has priority over i_start.
- Reset mid-operation, in ADD or DONE: the operation is abandoned. No o_done pulse occurs and o_sum/o_carry become 0.
- Latency:
  - Start accepted at edge 0.
  - ADD occupies the cycles after edges 0 through BITS-1 (BITS cycles).
  - o_done is high in the cycle after edge BITS, and o_sum/o_carry are valid from that same cycle.
  - Total start-to-done latency is BITS+1 edges.
- o_busy is high for exactly BITS cycles per operation and low in IDLE and DONE.
- Throughput: with i_start held high, one result every BITS+1 cycles. o_done pulses are separated by BITS cycles of o_done=0.
- All outputs are direct register outputs, with no combinational path from the inputs.

## Test plan

- Reset: hold i_reset for 2 cycles during an ADD. Required: o_busy=0, o_done=0, o_sum=0, o_carry=0 on the next cycle, and no o_done pulse afterwards.
- Basic (BITS=4): augend=9, addend=6, start at edge 0. Required: o_busy high for 4 cycles, then o_done=1 one cycle after edge 4 with o_sum=15, o_carry=0.
- Wrap/carry (BITS=4): 15+1 gives o_sum=0, o_carry=1; 15+15 gives o_sum=14, o_carry=1; 0+0 gives o_sum=0, o_carry=0.
- Ignored start: pulse i_start with augend=3, addend=3 during ADD of 5+2. Required: result 7, carry 0, and exactly one o_done pulse.
- Back-to-back: hold i_start high and present 1+2 then 8+8 in the DONE cycle. Required: o_done pulses 5 cycles apart with results 3/0 then 0/1, and o_sum holds 3 between the two pulses.
- Exhaustive (BITS=4): all 256 pairs x,y. Required: `{o_carry, o_sum}` == x+y at every o_done pulse. Repeat with BITS=1 and BITS=8, using random pairs for BITS=8.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial adder: one full adder plus a carry flop walks the operands LSB first
// and publishes {o_carry, o_sum} with a single-cycle done pulse.
module serial_adder #(
  parameter int BITS = 4
) (
  input  logic            i_clock,
  input  logic            i_reset,
  input  logic            i_start,
  input  logic [BITS-1:0] i_augend,
  input  logic [BITS-1:0] i_addend,
  output logic            o_busy,
  output logic            o_done,
  output logic [BITS-1:0] o_sum,
  output logic            o_carry
);

  localparam int NW = (BITS > 1) ? $clog2(BITS) : 1;

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [BITS-1:0] r_a;
  logic [BITS-1:0] r_b;
  logic [BITS-1:0] r_p;
  logic            r_c;
  logic [NW-1:0]   r_n;
  logic            r_busy;
  logic            r_done;
  logic [BITS-1:0] r_sum;
  logic            r_carry;

  logic            w_s;
  logic            w_c_next;
  logic [BITS-1:0] w_s_vec;
  logic [BITS-1:0] w_p_next;
  logic            w_last;
  logic            w_accept;

  assign w_s      = r_a[0] ^ r_b[0] ^ r_c;
  assign w_c_next = (r_a[0] & r_b[0]) | (r_a[0] & r_c) | (r_b[0] & r_c);
  assign w_s_vec  = BITS'(w_s);
  // The new sum bit enters at the MSB so that after BITS shifts P is LSB-aligned.
  assign w_p_next = (r_p >> 1) | (w_s_vec << (BITS - 1));
  assign w_last   = (r_n == NW'(BITS - 1));
  assign w_accept = i_start && ((r_state == IDLE) || (r_state == DONE));

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (i_start) w_next = ADD;
      ADD:     if (w_last)  w_next = DONE;
      DONE:    w_next = i_start ? ADD : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_a     <= '0;
      r_b     <= '0;
      r_p     <= '0;
      r_c     <= 1'b0;
      r_n     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sum   <= '0;
      r_carry <= 1'b0;
    end else begin
      r_busy <= (w_next == ADD);
      r_done <= (w_next == DONE);
      if (w_accept) begin
        r_a <= i_augend;
        r_b <= i_addend;
        r_p <= '0;
        r_c <= 1'b0;
        r_n <= '0;
      end else if (r_state == ADD) begin
        r_a <= r_a >> 1;
        r_b <= r_b >> 1;
        r_c <= w_c_next;
        r_p <= w_p_next;
        r_n <= r_n + NW'(1);
        // Outputs are loaded only from the final bit so partial sums never show.
        if (w_last) begin
          r_sum   <= w_p_next;
          r_carry <= w_c_next;
        end
      end
    end
  end

  assign o_busy  = r_busy;
  assign o_done  = r_done;
  assign o_sum   = r_sum;
  assign o_carry = r_carry;

endmodule
